// File: rtl/led_s2p_rx_if.sv
// LED shift-chain receiver bus: serial lines in, rebuilt word and status out.
// master = transmitter/observer side, slave = receiver.
interface led_s2p_rx_if #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 4
);
  logic                       sclk;
  logic                       sdin;
  logic                       sclrn;
  logic                       sen;
  logic [DATA_BITS-1:0]       pdata;
  logic                       valid;
  logic                       frame_err;
  logic [DATA_COUNT_BITS:0]   bit_cnt;

  modport master (
    output sclk, sdin, sclrn, sen,
    input  pdata, valid, frame_err, bit_cnt
  );

  modport slave (
    input  sclk, sdin, sclrn, sen,
    output pdata, valid, frame_err, bit_cnt
  );
endinterface

// File: rtl/led_s2p_rx.sv
// Oversampling serial-to-parallel receiver for the LED shift chain.
// Define LED_S2P_GLITCH_FILTER_EN to reject 1-cycle pulses on sclk/sen.
module led_s2p_rx #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 4,
  parameter int DIR             = 0,
  parameter int INV             = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  led_s2p_rx_if.slave  bus
);

  localparam int CW = DATA_COUNT_BITS + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BITS);
  localparam logic [DATA_BITS-1:0] INV_MASK =
    (INV != 0) ? {DATA_BITS{1'b1}} : {DATA_BITS{1'b0}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [2:0] sclk_q;
  logic [2:0] sen_q;
  logic [1:0] sdin_q;
  logic [1:0] sclrn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 3'b000;
      sen_q   <= 3'b000;
      sdin_q  <= 2'b00;
      sclrn_q <= 2'b11;
    end else begin
      sclk_q  <= {sclk_q[1:0], bus.sclk};
      sen_q   <= {sen_q[1:0], bus.sen};
      sdin_q  <= {sdin_q[0], bus.sdin};
      sclrn_q <= {sclrn_q[0], bus.sclrn};
    end
  end

  logic sclk_rise;
  logic sen_rise;

`ifdef LED_S2P_GLITCH_FILTER_EN
  logic sclk_f_q;
  logic sen_f_q;

  // filtered level only follows after two equal synchronized samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_f_q <= 1'b0;
      sen_f_q  <= 1'b0;
    end else begin
      if (sclk_q[1] == sclk_q[2]) sclk_f_q <= sclk_q[1];
      if (sen_q[1] == sen_q[2])   sen_f_q  <= sen_q[1];
    end
  end

  assign sclk_rise = sclk_q[1] & sclk_q[2] & ~sclk_f_q;
  assign sen_rise  = sen_q[1] & sen_q[2] & ~sen_f_q;
`else
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sen_rise  = sen_q[1] & ~sen_q[2];
`endif

  logic clr;
  logic bit_in;
  assign clr    = ~sclrn_q[1];
  assign bit_in = sdin_q[1];

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] pdata_q, pdata_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] shifted;
  logic [CW-1:0]        cnt_inc;

  generate
    if (DIR == 0) begin : g_dir_up
      assign shifted = {shreg_q[DATA_BITS-2:0], bit_in};
    end else begin : g_dir_dn
      assign shifted = {bit_in, shreg_q[DATA_BITS-1:1]};
    end
  endgenerate

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    shreg_d = shreg_q;
    pdata_d = pdata_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ovr_d   = 1'b0;
      shreg_d = '0;
    end else if (sen_rise) begin
      if (cnt_q == CNT_FULL && !ovr_q) begin
        pdata_d = shreg_q ^ INV_MASK;
        valid_d = 1'b1;
      end else begin
        ferr_d  = 1'b1;
      end
      state_d = S_IDLE;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (sclk_rise) begin
      unique case (state_q)
        S_IDLE, S_SHIFT: begin
          shreg_d = shifted;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CNT_FULL) ? S_FULL : S_SHIFT;
        end
        S_FULL:  ovr_d   = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      shreg_q <= '0;
      pdata_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      shreg_q <= shreg_d;
      pdata_q <= pdata_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.pdata     = pdata_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_led_s2p_rx.sv
// Bench for led_s2p_rx: INV=1 and INV=0 receivers fed the same serial lines,
// with a bit-list reference model and an event scoreboard.
module tb_led_s2p_rx;

  localparam int DB = 16;
  localparam int CB = 4;

  typedef struct packed {
    logic          err;
    logic [DB-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic sdin = 1'b0;
  logic sclrn = 1'b1;
  logic sen = 1'b0;

  always #5 clk = ~clk;

  led_s2p_rx_if #(.DATA_BITS(DB), .DATA_COUNT_BITS(CB)) b0 ();
  led_s2p_rx_if #(.DATA_BITS(DB), .DATA_COUNT_BITS(CB)) b1 ();

  assign b0.sclk  = sclk;
  assign b0.sdin  = sdin;
  assign b0.sclrn = sclrn;
  assign b0.sen   = sen;
  assign b1.sclk  = sclk;
  assign b1.sdin  = sdin;
  assign b1.sclrn = sclrn;
  assign b1.sen   = sen;

  led_s2p_rx #(.DATA_BITS(DB), .DATA_COUNT_BITS(CB), .DIR(0), .INV(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  led_s2p_rx #(.DATA_BITS(DB), .DATA_COUNT_BITS(CB), .DIR(0), .INV(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int checks = 0;
  int failures = 0;
  bit bits[$];
  exp_t q0[$];
  exp_t q1[$];
  logic [DB-1:0] last0 = '0;
  logic [DB-1:0] last1 = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // first bit received lands in the MSB
  function automatic logic [DB-1:0] model_word(input bit inv);
    logic [DB-1:0] w;
    w = '0;
    for (int i = 0; i < DB; i++) w[DB-1-i] = bits[i];
    return inv ? ~w : w;
  endfunction

  function automatic int exp_cnt();
    return (bits.size() > DB) ? DB : bits.size();
  endfunction

  task automatic check_cnt(input string nm);
    chk({nm, "_cnt0"}, 32'(b0.bit_cnt), exp_cnt());
    chk({nm, "_cnt1"}, 32'(b1.bit_cnt), exp_cnt());
  endtask

  task automatic mon(input int idx, input logic v, input logic e,
                     input logic [DB-1:0] pd);
    exp_t x;
    string tag;
    tag = $sformatf("dut%0d", idx);
    if ((idx == 0 ? q0.size() : q1.size()) == 0) begin
      chk({tag, "_unexpected_evt"}, {v, e}, 2'b00);
    end else begin
      x = (idx == 0) ? q0.pop_front() : q1.pop_front();
      chk({tag, "_evt_kind"}, {v, e}, x.err ? 2'b01 : 2'b10);
      chk({tag, "_pdata"}, 32'(pd), 32'(x.data));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (b0.valid || b0.frame_err) mon(0, b0.valid, b0.frame_err, b0.pdata);
      if (b1.valid || b1.frame_err) mon(1, b1.valid, b1.frame_err, b1.pdata);
    end
  end

  task automatic send_bit(input bit b);
    @(negedge clk) sdin = b;
    @(negedge clk) sclk = 1'b1;
    bits.push_back(b);
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [DB-1:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i % DB]);
  endtask

  task automatic do_latch();
    logic [DB-1:0] w0, w1;
    if (bits.size() == DB) begin
      w0 = model_word(1'b1);
      w1 = model_word(1'b0);
      q0.push_back({1'b0, w0});
      q1.push_back({1'b0, w1});
      last0 = w0;
      last1 = w1;
    end else begin
      q0.push_back({1'b1, last0});
      q1.push_back({1'b1, last1});
    end
    bits.delete();
    @(negedge clk) sen = 1'b1;
    repeat (4) @(negedge clk);
    sen = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk) sclrn = 1'b0;
    repeat (4) @(negedge clk);
    sclrn = 1'b1;
    bits.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int len;
    repeat (5) @(negedge clk);
    chk("rst_pdata", 32'(b0.pdata), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pdata", 32'(b0.pdata), 0);
    chk("idle_valid", {b0.valid, b1.valid}, 0);
    chk("idle_ferr", {b0.frame_err, b1.frame_err}, 0);
    check_cnt("idle");

    do_clear();
    for (int i = DB - 1; i >= 0; i--) begin
      logic [DB-1:0] w;
      w = 16'hFFD5;
      send_bit(w[i]);
      check_cnt("good_step");
    end
    do_latch();
    chk("good_pdata_spec", 32'(b0.pdata), 32'h002A);
    check_cnt("after_latch");

    send_word(16'(($urandom)), 15);
    check_cnt("short");
    do_latch();
    chk("short_hold", 32'(b0.pdata), 32'h002A);
    check_cnt("short_after");

    send_word(16'($urandom), 17);
    check_cnt("ovr");
    do_latch();
    send_word(16'h1234, 16);
    do_latch();
    chk("ovr_next_spec", 32'(b1.pdata), 32'h1234);

    send_word(16'($urandom), 8);
    check_cnt("mid8");
    do_clear();
    check_cnt("mid_clr");
    send_word(16'($urandom), 16);
    do_latch();

    send_word(16'($urandom), 8);
    @(negedge clk) sdin = 1'b1;
    @(negedge clk) sclk = 1'b1;
    @(negedge clk) sclk = 1'b0;
`ifndef LED_S2P_GLITCH_FILTER_EN
    bits.push_back(1'b1);
`endif
    repeat (8) @(negedge clk);
    check_cnt("glitch");
    while (bits.size() < DB) send_bit(1'($urandom));
    do_latch();

    send_word(16'($urandom), 16);
    @(negedge clk) sclrn = 1'b0;
    repeat (3) @(negedge clk);
    sen = 1'b1;
    repeat (4) @(negedge clk);
    sen = 1'b0;
    repeat (3) @(negedge clk);
    sclrn = 1'b1;
    bits.delete();
    repeat (4) @(negedge clk);
    check_cnt("latch_in_clr");

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 5))
        0: len = 15;
        1: len = 17;
        default: len = 16;
      endcase
      if ($urandom_range(0, 5) == 0) begin
        send_word(16'($urandom), 5);
        do_clear();
      end
      send_word(16'($urandom), len);
      check_cnt("rnd");
      do_latch();
    end

    send_word(16'($urandom), 5);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_cnt", 32'(b0.bit_cnt), 0);
    chk("midrst_pdata", {16'(b0.pdata), 16'(b1.pdata)}, 0);
    bits.delete();
    last0 = '0;
    last1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_word(16'($urandom), 16);
    do_latch();

    repeat (20) @(negedge clk);
    chk("pending_q0", q0.size(), 0);
    chk("pending_q1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_s2p_rx.md
Name: led_s2p_rx

Overview:
- Serial-to-parallel receiver for the LED shift-chain protocol: sclk, data, active-low clear, latch enable.
- Receives a frame from the GPIO parallel-to-serial LED driver and rebuilds the DATA_BITS-wide word.
- Oversamples all serial lines on the system clock; no second clock domain is used.
- Used as an on-board loopback/monitor for the LED chain and as the bench checker for the LED transmitter.

Parameters:
- DATA_BITS, 16, frame width in bits.
- DATA_COUNT_BITS, 4, log2(DATA_BITS); the internal bit counter is DATA_COUNT_BITS+1 bits wide.
- DIR, 0, shift direction. 0: each new bit enters bit 0 and older bits move toward the MSB, so the first bit received ends in the MSB. 1: each new bit enters the MSB and moves toward bit 0.
- INV, 1, 1: pdata is the bitwise inverse of the received bits (the driver sends inverted LED data). 0: no inversion.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sclk  in  1  serial shift clock from transmitter; bit captured on its rising edge
- sdin  in  1  serial data
- sclrn  in  1  active-low chain clear
- sen  in  1  latch enable; frame transferred on its rising edge
- pdata  out  DATA_BITS  last accepted word
- valid  out  1  one-cycle pulse when pdata updates
- frame_err  out  1  one-cycle pulse on a bad frame
- bit_cnt  out  DATA_COUNT_BITS+1  bits shifted since last clear or latch

Behaviour:
- Reset (rst_n low, asynchronous):
  - pdata=0, valid=0, frame_err=0, bit_cnt=0, shift register=0.
  - Synchronizer stages reset to idle levels: sclk=0, sdin=0, sclrn=1, sen=0.
- Input synchronization:
  - sclk, sdin, sclrn and sen each pass through a 2-flop synchronizer.
  - A third registered stage of sclk and sen provides rising-edge detection.
- Latency: a rising edge on sclk or sen at the pin acts on the 3rd clk rising edge after it.
- Timing requirement on the transmitter: sclk high and low phases each ≥3 clk periods; sdin stable from 1 clk before to 3 clk after the sclk rising edge.
- FSM states IDLE, SHIFT, FULL:
  - IDLE: bit_cnt=0. An sclk rise shifts in one bit, sets bit_cnt=1 and moves to SHIFT.
  - SHIFT: each sclk rise shifts in one bit and increments bit_cnt. When bit_cnt reaches DATA_BITS, move to FULL.
  - FULL: an sclk rise does not shift. It sets an internal overrun flag, and bit_cnt holds at DATA_BITS.
- Latch (sen rise, any state):
  - bit_cnt==DATA_BITS and no overrun: pdata <= shift register (inverted if INV=1); valid=1 for one cycle.
  - Otherwise: pdata unchanged; frame_err=1 for one cycle.
  - In both cases, on the next cycle: bit_cnt=0, overrun cleared, state=IDLE. The shift register is retained.
- Clear: synchronized sclrn low clears the shift register, bit_cnt and overrun, and forces IDLE. It holds the block there for as long as it is low. pdata is not affected.
- Priority in one cycle: clear > latch > shift.
  - A shift in the same cycle as a latch is dropped; the latch uses the pre-shift state.
  - A latch during clear is ignored: no valid, no frame_err.
- valid and frame_err are never asserted in the same cycle.
- rst_n asserted mid-frame: everything returns immediately to the reset values above.

Optional Feature:
- Macro LED_S2P_GLITCH_FILTER_EN.
- Defined:
  - Synchronized sclk and sen must hold the same value for 2 consecutive clk cycles before an edge is recognized; single-cycle pulses are ignored.
  - Latency becomes 4 clk cycles.
  - Minimum sclk phase becomes 4 clk periods.
- Undefined: no filtering; 3-cycle latency as above.

Test Plan:
- Reset then idle: rst_n low for 5 cycles, then high -> pdata=0x0000, valid=0, frame_err=0, bit_cnt=0.
- Good frame, DIR=0, INV=1:
  - Stimulus: sclrn low pulse, then bits of 0xFFD5 sent MSB first, 16 sclk rises at 4-clk phases, then sen rise.
  - Required: bit_cnt steps 1..16; pdata=0x002A; one valid pulse.
- Short frame: 15 bits, then sen rise -> frame_err pulse, pdata holds its prior value, bit_cnt returns to 0.
- Overrun: 17 bits, then sen rise -> frame_err pulse, pdata unchanged. A following good frame of 0x1234 (INV=0 build) -> pdata=0x1234, valid pulse.
- Clear mid-frame: after 8 bits, pull sclrn low for 4 clk -> bit_cnt=0. Then send a full 16-bit frame and latch -> valid pulse with the correct data.
- Glitch filter (macro defined): a 1-clk sclk pulse inserted mid-frame -> bit_cnt unchanged. Same stimulus with the macro undefined -> bit_cnt increments by 1.
